data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder at the far end of the CPU's memory-access port: it answers the load/store requests issued by the pipeline's memory-access stage. It holds a word-organised RAM with combinational read and synchronous write, flags out-of-range accesses, and honours the pipeline HALT. An optional memory-mapped I/O window adds a cycle counter, a store counter, a scratch register and a simulation-termination (TOHOST) register.

## Interface
- DEPTH_WORDS, 4096, number of 32-bit RAM words; power of two, ≤ 16320.
- CK_REF  input  1  clock; all state updates on its rising edge.
- RST  input  1  reset; synchronous, active-high.
- HALT  input  1  pipeline halt; suppresses all state updates except reset.
- MEM_ACCESS_READ_WRN  input  1  1 = read (idle default); 0 = store this cycle.
- MEM_ACCESS_ADDRESS_BUS  input  16  byte address.
- MEM_ACCESS_DATA_OUT_BUS  input  32  store data from the CPU, already sign-extended.
- MEM_ACCESS_DATA_IN_BUS  output  32  read data to the CPU, combinational.
- ACCESS_ERR  output  1  sticky out-of-range flag.
- SIM_DONE  output  1  sticky; set by a store to TOHOST (MMIO build only).
- TOHOST_CODE  output  32  value of the last TOHOST store.

## Operation
- Word index = ADDR[15:2]. ADDR[1:0] is ignored, so every access is a full 32-bit word. No byte enables.
- Decode priority:
  - MMIO window, ADDR ≥ 0xFF00, MMIO build only.
  - RAM, when index < DEPTH_WORDS.
  - Otherwise out-of-range.
- Read: the data bus shows the addressed word combinationally every cycle, whatever MEM_ACCESS_READ_WRN is. An out-of-range read returns 0 and does not set ACCESS_ERR, because idle cycles drive address 0 and reads are speculative.
- Store: accepted when READ_WRN=0, HALT=0 and RST=0. The word is written at the clock edge. Read-during-write to the same address returns the old contents in that cycle and the new value from the next cycle.
- An out-of-range store is dropped and sets ACCESS_ERR at the next edge. ACCESS_ERR clears only on RST.
- MMIO map, word-aligned; unlisted MMIO addresses read 0 and ignore stores:
  - 0xFF00 CYCLE_LO, read-only.
  - 0xFF04 CYCLE_HI, read-only.
  - 0xFF08 TOHOST: a store sets SIM_DONE=1 and loads TOHOST_CODE; reads return TOHOST_CODE.
  - 0xFF0C SCRATCH, read/write.
  - 0xFF10 STORE_COUNT, read-only.
- Stores to read-only MMIO registers are dropped and do not set ACCESS_ERR.
- CYCLE is a 64-bit counter. It increments every edge with RST=0 and HALT=0 and wraps from 2^64−1 to 0. LO and HI are read independently, with no atomic snapshot.
- STORE_COUNT is a 32-bit counter. It increments on every accepted store, including RAM, MMIO and dropped read-only stores, but not out-of-range stores. It wraps at 2^32.
- A later TOHOST store overwrites TOHOST_CODE; SIM_DONE stays 1.

## Timing
- Read latency: 0 cycles (combinational address to data). The CPU samples the data at the next edge.
- Write latency: 1 edge; visible to reads in the following cycle.
- Reset values:
  - ACCESS_ERR=0, SIM_DONE=0, TOHOST_CODE=0.
  - CYCLE=0, STORE_COUNT=0, SCRATCH=0.
  - MEM_ACCESS_DATA_IN_BUS follows the address combinationally.
  - RAM contents are not reset and are undefined until written.
- RST asserted in the same cycle as a store: RST wins, the store is dropped and counters go to 0.
- HALT held with READ_WRN=0: no write for the whole halt. The store is performed on the first edge after HALT drops, if still presented.
- No busy/ready signal; the block accepts one access every cycle.

## Configuration
- DMEM_MMIO_EN defined:
  - MMIO window decoded as above.
  - SIM_DONE and TOHOST_CODE are functional.
- DMEM_MMIO_EN undefined:
  - No MMIO logic. Addresses ≥ 0xFF00 decode as RAM if in range, otherwise out-of-range.
  - SIM_DONE and TOHOST_CODE are tied to 0.
  - No cycle or store counters.

## Test plan
- Write/read and low-bit aliasing: after RST, store 0xCAFEBABE to 0x0010, then read 0x0010 and 0x0012 → both return 0xCAFEBABE.
- Read-during-write: with 0x0010 holding 0xCAFEBABE, store 0x12345678 to 0x0010 → bus shows 0xCAFEBABE that cycle and 0x12345678 the next.
- HALT: HALT=1 for 3 cycles while storing 0xFFFFFFFF to 0x0020 → word unchanged, STORE_COUNT unchanged, CYCLE frozen. Drop HALT → word becomes 0xFFFFFFFF.
- Out-of-range (DEPTH_WORDS=4096, MMIO off): read 0x8000 → 0 and ACCESS_ERR stays 0. Store to 0x8000 → ACCESS_ERR=1 next cycle and stays 1 until RST.
- MMIO (DMEM_MMIO_EN):
  - Read CYCLE_LO 10 unhalted edges after RST release → 10.
  - Store 0x00000001 to 0xFF08 → SIM_DONE=1 and TOHOST_CODE=1 next cycle.
  - Store to 0xFF00 → CYCLE unaffected, STORE_COUNT increments by 1.
- Reset mid-operation: assert RST together with a store to 0xFF0C (SCRATCH) and a store to 0x0030 in consecutive cycles → SCRATCH=0, counters=0, 0x0030 unchanged.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering the CPU memory-access stage.
// Define DMEM_MMIO_EN to add the cycle/store/scratch/TOHOST MMIO window.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic        CK_REF,
    input  logic        RST,
    input  logic        HALT,
    input  logic        MEM_ACCESS_READ_WRN,
    input  logic [15:0] MEM_ACCESS_ADDRESS_BUS,
    input  logic [31:0] MEM_ACCESS_DATA_OUT_BUS,
    output logic [31:0] MEM_ACCESS_DATA_IN_BUS,
    output logic        ACCESS_ERR,
    output logic        SIM_DONE,
    output logic [31:0] TOHOST_CODE
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];
    logic [13:0] idx;
    logic        in_range;
    logic        mmio_hit;
    logic        store;
    logic        ram_we;
    logic [31:0] ram_rd;
    logic [1:0]  unused_lsb;

    assign idx        = MEM_ACCESS_ADDRESS_BUS[15:2];
    assign unused_lsb = MEM_ACCESS_ADDRESS_BUS[1:0];
    assign in_range   = {18'd0, idx} < 32'(DEPTH_WORDS);
    assign store      = !MEM_ACCESS_READ_WRN && !HALT && !RST;
    assign ram_we     = store && !mmio_hit && in_range;
    assign ram_rd     = in_range ? mem[idx[AW-1:0]] : 32'd0;

    always_ff @(posedge CK_REF) begin
        if (ram_we)
            mem[idx[AW-1:0]] <= MEM_ACCESS_DATA_OUT_BUS;
    end

    // Out-of-range reads are speculative; only stores raise the flag.
    always_ff @(posedge CK_REF) begin
        if (RST)
            ACCESS_ERR <= 1'b0;
        else if (store && !mmio_hit && !in_range)
            ACCESS_ERR <= 1'b1;
    end

`ifdef DMEM_MMIO_EN
    logic [63:0] cycle_cnt;
    logic [31:0] store_cnt;
    logic [31:0] scratch;
    logic [31:0] tohost_code;
    logic        sim_done;
    logic [5:0]  woff;
    logic [31:0] mmio_rd;

    assign mmio_hit = &MEM_ACCESS_ADDRESS_BUS[15:8];
    assign woff     = MEM_ACCESS_ADDRESS_BUS[7:2];

    always_comb begin
        mmio_rd = 32'd0;
        case (woff)
            6'h00:   mmio_rd = cycle_cnt[31:0];
            6'h01:   mmio_rd = cycle_cnt[63:32];
            6'h02:   mmio_rd = tohost_code;
            6'h03:   mmio_rd = scratch;
            6'h04:   mmio_rd = store_cnt;
            default: mmio_rd = 32'd0;
        endcase
    end

    always_ff @(posedge CK_REF) begin
        if (RST) begin
            cycle_cnt   <= 64'd0;
            store_cnt   <= 32'd0;
            scratch     <= 32'd0;
            tohost_code <= 32'd0;
            sim_done    <= 1'b0;
        end else if (!HALT) begin
            cycle_cnt <= cycle_cnt + 64'd1;
            // Read-only MMIO stores still count as accepted.
            if (store && (mmio_hit || in_range))
                store_cnt <= store_cnt + 32'd1;
            if (store && mmio_hit) begin
                case (woff)
                    6'h02: begin
                        sim_done    <= 1'b1;
                        tohost_code <= MEM_ACCESS_DATA_OUT_BUS;
                    end
                    6'h03:   scratch <= MEM_ACCESS_DATA_OUT_BUS;
                    default: ;
                endcase
            end
        end
    end

    assign MEM_ACCESS_DATA_IN_BUS = mmio_hit ? mmio_rd : ram_rd;
    assign SIM_DONE               = sim_done;
    assign TOHOST_CODE            = tohost_code;
`else
    assign mmio_hit               = 1'b0;
    assign MEM_ACCESS_DATA_IN_BUS = ram_rd;
    assign SIM_DONE               = 1'b0;
    assign TOHOST_CODE            = 32'd0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a behavioural model.
// Exercises the MMIO window only when DMEM_MMIO_EN is defined.
module tb_data_mem_responder;

    localparam int DEPTH = 4096;
`ifdef DMEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        rwn;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_bus;
    logic        err;
    logic        done;
    logic [31:0] tohost;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .CK_REF                 (clk),
        .RST                    (rst),
        .HALT                   (halt),
        .MEM_ACCESS_READ_WRN    (rwn),
        .MEM_ACCESS_ADDRESS_BUS (addr),
        .MEM_ACCESS_DATA_OUT_BUS(wdata),
        .MEM_ACCESS_DATA_IN_BUS (rd_bus),
        .ACCESS_ERR             (err),
        .SIM_DONE               (done),
        .TOHOST_CODE            (tohost)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_mem [int];
    logic        m_err;
    logic        m_done;
    logic [31:0] m_code;
    logic [63:0] m_cycle;
    logic [31:0] m_sc;
    logic [31:0] m_scratch;

    // {known, value} of what a read of address a must return now
    function automatic logic [32:0] exp_rd(input logic [15:0] a);
        int w;
        w = int'(a[15:2]);
        if (MMIO && a >= 16'hFF00) begin
            case (a[7:2])
                6'h00:   return {1'b1, m_cycle[31:0]};
                6'h01:   return {1'b1, m_cycle[63:32]};
                6'h02:   return {1'b1, m_code};
                6'h03:   return {1'b1, m_scratch};
                6'h04:   return {1'b1, m_sc};
                default: return {1'b1, 32'd0};
            endcase
        end
        if (w < DEPTH) begin
            if (m_mem.exists(w))
                return {1'b1, m_mem[w]};
            return 33'd0;
        end
        return {1'b1, 32'd0};
    endfunction

    task automatic model_edge();
        int w;
        w = int'(addr[15:2]);
        if (rst) begin
            m_err     = 1'b0;
            m_done    = 1'b0;
            m_code    = 32'd0;
            m_cycle   = 64'd0;
            m_sc      = 32'd0;
            m_scratch = 32'd0;
        end else if (!halt) begin
            m_cycle = m_cycle + 64'd1;
            if (!rwn) begin
                if (MMIO && addr >= 16'hFF00) begin
                    m_sc = m_sc + 32'd1;
                    if (addr[7:2] == 6'h02) begin
                        m_done = 1'b1;
                        m_code = wdata;
                    end else if (addr[7:2] == 6'h03) begin
                        m_scratch = wdata;
                    end
                end else if (w < DEPTH) begin
                    m_sc     = m_sc + 32'd1;
                    m_mem[w] = wdata;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic h, input logic rw,
                         input logic [15:0] a, input logic [31:0] d);
        rst   = r;
        halt  = h;
        rwn   = rw;
        addr  = a;
        wdata = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 1, 16'h0000, 32'd0);
        tick();
        tick();
        drive(0, 0, 1, 16'h0000, 32'd0);
        n_chk++;
        if (err !== 1'b0 || err !== m_err) begin
            n_fail++;
            $display("FAIL reset_err got %b want 0", err);
        end
        n_chk++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got %b want 0", done);
        end
        n_chk++;
        if (tohost !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_tohost got %h want 0", tohost);
        end
    endtask

    task automatic test_cycle();
        logic [32:0] e;
        drive(0, 0, 1, 16'hFF00, 32'd0);
        repeat (10) tick();
        e = exp_rd(addr);
        n_chk++;
        if (rd_bus !== 32'd10 || rd_bus !== e[31:0]) begin
            n_fail++;
            $display("FAIL cycle_lo got %0d want 10", rd_bus);
        end
        drive(0, 0, 1, 16'hFF04, 32'd0);
        n_chk++;
        if (rd_bus !== 32'd0) begin
            n_fail++;
            $display("FAIL cycle_hi got %h want 0", rd_bus);
        end
    endtask

    task automatic test_write_read();
        logic [32:0] e;
        drive(0, 0, 0, 16'h0010, 32'hCAFEBABE);
        tick();
        drive(0, 0, 1, 16'h0010, 32'd0);
        e = exp_rd(addr);
        n_chk++;
        if (rd_bus !== 32'hCAFEBABE || rd_bus !== e[31:0]) begin
            n_fail++;
            $display("FAIL wr_rd got %h want cafebabe", rd_bus);
        end
        drive(0, 0, 1, 16'h0012, 32'd0);
        n_chk++;
        if (rd_bus !== 32'hCAFEBABE) begin
            n_fail++;
            $display("FAIL alias got %h want cafebabe", rd_bus);
        end
    endtask

    task automatic test_rdw();
        drive(0, 0, 0, 16'h0010, 32'h12345678);
        n_chk++;
        if (rd_bus !== 32'hCAFEBABE) begin
            n_fail++;
            $display("FAIL rdw_old got %h want cafebabe", rd_bus);
        end
        tick();
        drive(0, 0, 1, 16'h0010, 32'd0);
        n_chk++;
        if (rd_bus !== 32'h12345678) begin
            n_fail++;
            $display("FAIL rdw_new got %h want 12345678", rd_bus);
        end
    endtask

    task automatic test_halt();
        logic [32:0] e;
        logic [31:0] sc0;
        logic [31:0] cy0;
        drive(0, 0, 0, 16'h0020, 32'd0);
        tick();
        sc0 = m_sc;
        cy0 = m_cycle[31:0];
        drive(0, 1, 0, 16'h0020, 32'hFFFFFFFF);
        repeat (3) begin
            tick();
            e = exp_rd(addr);
            n_chk++;
            if (rd_bus !== 32'd0 || rd_bus !== e[31:0]) begin
                n_fail++;
                $display("FAIL halt_word got %h want 0", rd_bus);
            end
        end
`ifdef DMEM_MMIO_EN
        drive(0, 1, 1, 16'hFF10, 32'd0);
        n_chk++;
        if (rd_bus !== sc0) begin
            n_fail++;
            $display("FAIL halt_sc got %h want %h", rd_bus, sc0);
        end
        drive(0, 1, 1, 16'hFF00, 32'd0);
        n_chk++;
        if (rd_bus !== cy0) begin
            n_fail++;
            $display("FAIL halt_cycle got %h want %h", rd_bus, cy0);
        end
`endif
        drive(0, 0, 0, 16'h0020, 32'hFFFFFFFF);
        tick();
        drive(0, 0, 1, 16'h0020, 32'd0);
        n_chk++;
        if (rd_bus !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL halt_release got %h want ffffffff", rd_bus);
        end
    endtask

    task automatic test_oor();
        drive(1, 0, 1, 16'h0000, 32'd0);
        tick();
        drive(0, 0, 1, 16'h8000, 32'd0);
        n_chk++;
        if (rd_bus !== 32'd0) begin
            n_fail++;
            $display("FAIL oor_read got %h want 0", rd_bus);
        end
        tick();
        n_chk++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_read_err got %b want 0", err);
        end
        drive(0, 0, 0, 16'h8000, 32'h5A5A5A5A);
        tick();
        drive(0, 0, 1, 16'h0000, 32'd0);
        repeat (3) begin
            n_chk++;
            if (err !== 1'b1 || err !== m_err) begin
                n_fail++;
                $display("FAIL oor_sticky got %b want 1", err);
            end
            tick();
        end
        drive(1, 0, 1, 16'h0000, 32'd0);
        tick();
        drive(0, 0, 1, 16'h0000, 32'd0);
        n_chk++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_clear got %b want 0", err);
        end
    endtask

    task automatic test_mmio();
        logic [32:0] e;
        drive(0, 0, 0, 16'hFF08, 32'h00000001);
        tick();
        drive(0, 0, 1, 16'hFF08, 32'd0);
        n_chk++;
        if (done !== 1'b1 || tohost !== 32'd1) begin
            n_fail++;
            $display("FAIL tohost got %b/%h want 1/1", done, tohost);
        end
        n_chk++;
        if (rd_bus !== 32'd1) begin
            n_fail++;
            $display("FAIL tohost_rd got %h want 1", rd_bus);
        end
        drive(0, 0, 0, 16'hFF00, 32'hDEADBEEF);
        tick();
        drive(0, 0, 1, 16'hFF10, 32'd0);
        e = exp_rd(addr);
        n_chk++;
        if (rd_bus !== e[31:0]) begin
            n_fail++;
            $display("FAIL ro_sc got %h want %h", rd_bus, e[31:0]);
        end
        drive(0, 0, 1, 16'hFF00, 32'd0);
        e = exp_rd(addr);
        n_chk++;
        if (rd_bus !== e[31:0]) begin
            n_fail++;
            $display("FAIL ro_cycle got %h want %h", rd_bus, e[31:0]);
        end
        drive(0, 0, 0, 16'hFF08, 32'h00000077);
        tick();
        n_chk++;
        if (done !== 1'b1 || tohost !== 32'h77) begin
            n_fail++;
            $display("FAIL tohost2 got %b/%h want 1/77", done, tohost);
        end
    endtask

    task automatic test_random();
        logic [32:0] e;
        logic [15:0] a;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = 16'($urandom_range(0, 16'h7F));
                2:       a = 16'hFF00 + 16'($urandom_range(0, 31));
                default: a = 16'h8000 + 16'($urandom_range(0, 16'h7FFF));
            endcase
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)), a, $urandom);
            e = exp_rd(addr);
            if (e[32]) begin
                n_chk++;
                if (rd_bus !== e[31:0]) begin
                    n_fail++;
                    $display("FAIL rnd_rd @%h got %h want %h",
                             addr, rd_bus, e[31:0]);
                end
            end
            n_chk++;
            if (err !== m_err || done !== m_done || tohost !== m_code) begin
                n_fail++;
                $display("FAIL rnd_flags got %b/%b/%h want %b/%b/%h",
                         err, done, tohost, m_err, m_done, m_code);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 16'h0030, 32'h0BADF00D);
        tick();
        drive(0, 0, 0, 16'hFF0C, 32'h00000055);
        tick();
        drive(1, 0, 0, 16'hFF0C, 32'h00000099);
        tick();
        drive(1, 0, 0, 16'h0030, 32'h11111111);
        tick();
        drive(0, 0, 1, 16'h0030, 32'd0);
        n_chk++;
        if (rd_bus !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL rst_ram got %h want 0badf00d", rd_bus);
        end
        n_chk++;
        if (err !== 1'b0 || done !== 1'b0 || tohost !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_flags got %b/%b/%h want 0/0/0",
                     err, done, tohost);
        end
`ifdef DMEM_MMIO_EN
        drive(0, 0, 1, 16'hFF0C, 32'd0);
        n_chk++;
        if (rd_bus !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_scratch got %h want 0", rd_bus);
        end
        drive(0, 0, 1, 16'hFF10, 32'd0);
        n_chk++;
        if (rd_bus !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_sc got %h want 0", rd_bus);
        end
        drive(0, 0, 1, 16'hFF00, 32'd0);
        n_chk++;
        if (rd_bus !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_cycle got %h want 0", rd_bus);
        end
`endif
    endtask

    initial begin
        rst       = 1'b1;
        halt      = 1'b0;
        rwn       = 1'b1;
        addr      = 16'd0;
        wdata     = 32'd0;
        m_err     = 1'b0;
        m_done    = 1'b0;
        m_code    = 32'd0;
        m_cycle   = 64'd0;
        m_sc      = 32'd0;
        m_scratch = 32'd0;
        test_reset();
`ifdef DMEM_MMIO_EN
        test_cycle();
`endif
        test_write_read();
        test_rdw();
        test_halt();
        test_oor();
`ifdef DMEM_MMIO_EN
        test_mmio();
`endif
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
